axis_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one AXI-stream output among N AXI-stream requesters. It owns a single registered output stage, so it can feed the downstream stream datapath directly. A grant is held from the first beat of a packet through its `tlast` beat, which guarantees packets are never interleaved.

---
 rtl/axis_pkg.sv | 16 +
 rtl/axis_rr_arbiter_if.sv | 26 ++
 rtl/axis_rr_arbiter_rr_pick.sv | 46 ++++
 rtl/axis_rr_arbiter.sv | 113 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the packet round-robin AXI-stream arbiter.
package axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    localparam int AXIS_DW = 8;

    // Index width for n ports; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// N requester streams in, one arbitrated stream out.
interface axis_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = axis_pkg::AXIS_DW
);
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;

    // Arbiter side.
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tvalid, m_tlast
    );

    // Requesters plus downstream sink.
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting port at or above ptr, modulo N.
module rr_pick
    import axis_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);
    localparam int SW = IW + 1;

    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_enc;
    logic          w_any;
    logic [SW-1:0] w_back;

    // Rotate so that the port at ptr lands in slot 0.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            logic [SW-1:0] w_sum;
            logic [SW-1:0] w_wrap;
            assign w_sum      = SW'(gi) + {1'b0, ptr};
            assign w_wrap     = (w_sum >= SW'(N)) ? (w_sum - SW'(N)) : w_sum;
            assign w_rot[gi]  = req[IW'(w_wrap)];
        end
    endgenerate

    always_comb begin
        w_enc = '0;
        w_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = IW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_back  = {1'b0, w_enc} + {1'b0, ptr};
    assign gnt_idx = (w_back >= SW'(N)) ? IW'(w_back - SW'(N)) : IW'(w_back);
    assign any     = w_any;

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: grant held from first beat to tlast,
// single registered output stage feeding the downstream stream.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = AXIS_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_rr_arbiter_if.slave          bus,
    output logic [idx_width(N)-1:0]   g_idx,
    output logic                      g_busy
);
    localparam int IW = idx_width(N);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_gidx;
    logic [DW-1:0] r_mdata;
    logic          r_mvalid;
    logic          r_mlast;

    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic          w_out_free;
    logic [N-1:0]  w_sready;
    logic          w_accept;
    logic          w_sel_last;
    logic [DW-1:0] w_sel_data;
    logic          w_pkt_end;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (bus.s_tvalid),
        .ptr     (r_ptr),
        .gnt_idx (w_pick_idx),
        .any     (w_pick_any)
    );

    // Output slot can take a beat if empty or draining this cycle.
    assign w_out_free = !r_mvalid || bus.m_tready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign w_sready[gi] = (r_state == XFER) && (r_gidx == IW'(gi)) && w_out_free;
        end
    endgenerate

    assign w_accept   = |(w_sready & bus.s_tvalid);
    assign w_sel_last = bus.s_tlast[r_gidx];
    assign w_sel_data = bus.s_tdata[r_gidx*DW +: DW];
    assign w_pkt_end  = w_accept && w_sel_last;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_state_next = XFER;
            XFER:    if (w_pkt_end)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant is captured only when leaving IDLE; ptr moves past the served port at tlast.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gidx <= '0;
            r_ptr  <= '0;
        end else begin
            if (r_state == IDLE && w_pick_any) begin
                r_gidx <= w_pick_idx;
            end
            if (w_pkt_end) begin
                r_ptr <= (r_gidx == IW'(N - 1)) ? '0 : (r_gidx + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mdata  <= '0;
            r_mlast  <= 1'b0;
            r_mvalid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mdata  <= w_sel_data;
                r_mlast  <= w_sel_last;
                r_mvalid <= 1'b1;
            end else if (bus.m_tready) begin
                r_mvalid <= 1'b0;
            end
        end
    end

    assign bus.s_tready = w_sready;
    assign bus.m_tdata  = r_mdata;
    assign bus.m_tvalid = r_mvalid;
    assign bus.m_tlast  = r_mlast;
    assign g_idx        = r_gidx;
    assign g_busy       = (r_state == XFER);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed scenarios plus randomized traffic for axis_rr_arbiter, checked against a
// behavioural model of the arbitration rules and a per-port packet scoreboard.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    typedef logic [7:0] seq_t [8];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] g_idx;
    logic       g_busy;

    axis_rr_arbiter_if #(.N(N), .DW(DW)) bus();

    axis_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .g_idx  (g_idx),
        .g_busy (g_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         mb_busy;
    int         mb_port;
    int         mb_ptr;
    bit         mo_v;
    logic [7:0] mo_d;
    bit         mo_l;
    int         acc_port;

    // Directed sources
    logic [7:0] d_data [4][8];
    int         d_len [4];
    int         d_pos [4];
    bit         d_en  [4];

    // Random sources and scoreboard
    bit rnd_mode, fair_mode;
    int fixed_len;
    int src_seq [4], src_pkt [4], src_pos [4];
    int dl_seq [4], dl_pkt [4], dl_pos [4];
    bit in_pkt;
    int pkt_owner;

    logic [7:0] dlv [$];
    logic [7:0] grants [$];
    int         gcyc [$];
    bit         prev_busy;
    int         cyc;
    int         stall_left, gap_left;
    bit         stalled, gap_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_seq(input string tag, input logic [7:0] q [$], input int n, input seq_t e);
        chk({tag, "_len"}, q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < q.size()) chk(tag, q[i], e[i]);
        end
    endtask

    function automatic int plen(input int p, input int k);
        if (fixed_len > 0) return fixed_len;
        return ((p * 3 + k) % 4) + 1;
    endfunction

    function automatic int rr_winner(input int ptr, input logic [3:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mb_busy = 0; mb_port = 0; mb_ptr = 0;
        mo_v = 0; mo_d = 8'h00; mo_l = 0;
    endtask

    task automatic clr();
        for (int p = 0; p < N; p++) begin
            d_len[p] = 0; d_pos[p] = 0; d_en[p] = 1;
        end
        rnd_mode = 0; fair_mode = 0; fixed_len = 0;
        bus.m_tready = 1'b1;
        dlv.delete(); grants.delete(); gcyc.delete();
    endtask

    task automatic src_reset();
        for (int p = 0; p < N; p++) begin
            src_seq[p] = 0; src_pkt[p] = 0; src_pos[p] = 0;
            dl_seq[p] = 0; dl_pkt[p] = 0; dl_pos[p] = 0;
        end
        in_pkt = 0; pkt_owner = 0;
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (rnd_mode) begin
                bus.s_tvalid[p]         = fair_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
                bus.s_tdata[p*8 +: 8]   = {2'(p), 6'(src_seq[p])};
                bus.s_tlast[p]          = (src_pos[p] == plen(p, src_pkt[p]) - 1);
            end else begin
                bus.s_tvalid[p]         = d_en[p] && (d_pos[p] < d_len[p]);
                bus.s_tdata[p*8 +: 8]   = d_data[p][d_pos[p] % 8];
                bus.s_tlast[p]          = (d_pos[p] == d_len[p] - 1);
            end
        end
        if (rnd_mode && !fair_mode) bus.m_tready = ($urandom_range(0, 3) != 0);
    endtask

    // Compare every observable against the model, then decide what this edge accepts.
    task automatic observe();
        logic [3:0] exp_ready;
        #1;
        if (!rst) model_reset();
        exp_ready = (mb_busy && (!mo_v || bus.m_tready)) ? 4'(1 << mb_port) : 4'b0000;
        chk("s_tready", bus.s_tready, exp_ready);
        chk("g_busy",   g_busy,       mb_busy);
        chk("g_idx",    g_idx,        mb_port);
        chk("m_tvalid", bus.m_tvalid, mo_v);
        chk("m_tdata",  bus.m_tdata,  mo_d);
        chk("m_tlast",  bus.m_tlast,  mo_l);
        acc_port = (rst && exp_ready != 4'b0000 && bus.s_tvalid[mb_port]) ? mb_port : -1;
        if (g_busy === 1'b1 && !prev_busy) begin
            grants.push_back(8'(g_idx));
            gcyc.push_back(cyc);
        end
        prev_busy = (g_busy === 1'b1);
    endtask

    task automatic sb_deliver(input logic [7:0] d, input logic l);
        int p;
        p = int'(d[7:6]);
        if (in_pkt) chk("no_interleave", p, pkt_owner);
        chk("sb_data", d, {2'(p), 6'(dl_seq[p])});
        chk("sb_last", l, dl_pos[p] == plen(p, dl_pkt[p]) - 1);
        dl_seq[p]++;
        if (dl_pos[p] == plen(p, dl_pkt[p]) - 1) begin
            dl_pkt[p]++; dl_pos[p] = 0;
        end else begin
            dl_pos[p]++;
        end
        in_pkt = !l; pkt_owner = p;
    endtask

    task automatic advance();
        int w;
        if (rst && bus.m_tvalid && bus.m_tready) begin
            dlv.push_back(bus.m_tdata);
            if (rnd_mode) sb_deliver(bus.m_tdata, bus.m_tlast);
        end
        if (rst) begin
            if (acc_port >= 0) begin
                mo_v = 1; mo_d = bus.s_tdata[acc_port*8 +: 8]; mo_l = bus.s_tlast[acc_port];
            end else if (bus.m_tready) begin
                mo_v = 0;
            end
            if (!mb_busy) begin
                w = rr_winner(mb_ptr, bus.s_tvalid);
                if (w >= 0) begin mb_busy = 1; mb_port = w; end
            end else if (acc_port >= 0 && bus.s_tlast[acc_port]) begin
                mb_busy = 0; mb_ptr = (mb_port + 1) % N;
            end
            if (acc_port >= 0) begin
                if (rnd_mode) begin
                    src_seq[acc_port]++;
                    if (bus.s_tlast[acc_port]) begin
                        src_pkt[acc_port]++; src_pos[acc_port] = 0;
                    end else begin
                        src_pos[acc_port]++;
                    end
                end else begin
                    d_pos[acc_port]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) begin drive(); observe(); advance(); end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0;
        observe(); advance();
        rst = 1'b1;
        src_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_tvalid = '0; bus.s_tlast = '0; bus.s_tdata = '0; bus.m_tready = 1'b0;
        cyc = 0; prev_busy = 0; acc_port = -1;
        model_reset(); clr(); src_reset();
        @(negedge clk);

        // Reset held with random inputs
        repeat (3) begin
            bus.s_tvalid = 4'($urandom); bus.s_tlast = 4'($urandom);
            bus.s_tdata = $urandom; bus.m_tready = 1'($urandom);
            observe();
            chk("rst_s_tready", bus.s_tready, 4'b0000);
            chk("rst_m_tvalid", bus.m_tvalid, 1'b0);
            advance();
        end
        rst = 1'b1;
        clr();
        run(3);
        chk("idle_after_rst", g_busy, 1'b0);

        // Single requester on port 2
        d_data[2][0] = 8'hA1; d_data[2][1] = 8'hA2; d_data[2][2] = 8'hA3; d_len[2] = 3;
        for (int c = 0; c < 8; c++) begin
            drive(); observe();
            if (c >= 1 && c <= 3) chk("single_gidx", g_idx, 2'd2);
            if (c >= 1 && c <= 3) chk("single_busy", g_busy, 1'b1);
            if (c >= 2 && c <= 4) begin
                chk("single_data", bus.m_tdata, 8'hA0 + 8'(c - 1));
                chk("single_last", bus.m_tlast, c == 4);
            end
            if (c == 4) chk("single_busy_fall", g_busy, 1'b0);
            if (c == 5) chk("single_drain", bus.m_tvalid, 1'b0);
            advance();
        end
        chk_seq("single_dlv", dlv, 3, '{8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0, 0});

        // Fairness: all ports, 2-beat packets
        do_reset(); clr();
        rnd_mode = 1; fair_mode = 1; fixed_len = 2;
        for (int c = 0; c < 40; c++) begin
            if (grants.size() >= 6) break;
            drive(); observe(); advance();
        end
        chk_seq("fair_order", grants, 6, '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 0, 0});
        for (int i = 1; i < gcyc.size(); i++) chk("fair_gap", gcyc[i] - gcyc[i-1], 3);

        // Backpressure on port 1 while 0x55 sits in the output register
        do_reset(); clr();
        d_data[1][0] = 8'h54; d_data[1][1] = 8'h55; d_data[1][2] = 8'h56; d_len[1] = 3;
        stall_left = 0; stalled = 0;
        for (int c = 0; c < 20; c++) begin
            drive();
            if (!stalled && bus.m_tvalid && bus.m_tdata == 8'h55) begin
                stall_left = 3; stalled = 1;
            end
            bus.m_tready = (stall_left == 0);
            observe();
            if (stall_left > 0) begin
                chk("bp_data", bus.m_tdata, 8'h55);
                chk("bp_valid", bus.m_tvalid, 1'b1);
                chk("bp_ready1", bus.s_tready[1], 1'b0);
                stall_left--;
            end
            advance();
        end
        chk("bp_stalled", stalled, 1'b1);
        chk_seq("bp_dlv", dlv, 3, '{8'h54, 8'h55, 8'h56, 0, 0, 0, 0, 0});

        // Valid gap on port 1 with port 3 waiting
        do_reset(); clr();
        for (int i = 0; i < 4; i++) d_data[1][i] = 8'h10 + 8'(i);
        d_len[1] = 4;
        d_data[3][0] = 8'h30; d_len[3] = 1;
        gap_left = 0; gap_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (d_pos[1] == 2 && !gap_done) begin gap_left = 2; gap_done = 1; end
            d_en[1] = (gap_left == 0);
            drive(); observe();
            if (g_busy && d_pos[1] < 4) chk("gap_gidx", g_idx, 2'd1);
            if (gap_left > 0) gap_left--;
            advance();
        end
        chk_seq("gap_order", grants, 2, '{8'd1, 8'd3, 0, 0, 0, 0, 0, 0});
        chk_seq("gap_dlv", dlv, 5, '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 0, 0, 0});

        // Reset in the middle of a 4-beat packet from port 0
        do_reset(); clr();
        d_data[2][0] = 8'h2F; d_len[2] = 1;
        run(4);
        for (int i = 0; i < 4; i++) d_data[0][i] = 8'h01 + 8'(i);
        d_len[0] = 4;
        for (int c = 0; c < 12; c++) begin
            if (d_pos[0] >= 2) break;
            drive(); observe(); advance();
        end
        chk("mid_reach", d_pos[0], 2);
        rst = 1'b0;
        drive(); observe();
        chk("mid_rst_mvalid", bus.m_tvalid, 1'b0);
        chk("mid_rst_ready", bus.s_tready, 4'b0000);
        advance();
        run(1);
        rst = 1'b1;
        clr();
        d_data[1][0] = 8'h1A; d_len[1] = 1;
        d_data[3][0] = 8'h3A; d_len[3] = 1;
        run(8);
        chk_seq("mid_order", grants, 2, '{8'd1, 8'd3, 0, 0, 0, 0, 0, 0});
        chk_seq("mid_dlv", dlv, 2, '{8'h1A, 8'h3A, 0, 0, 0, 0, 0, 0});

        // Randomized traffic with random backpressure
        do_reset(); clr();
        rnd_mode = 1;
        run(600);
        chk("rand_progress", dlv.size() > 50, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
